// File: rtl/icache_way_array.sv
// icache_way_array: multi-way icache data/valid storage with invalidate sweep; define ICACHE_WAY_BYPASS_EN for write-first collision forwarding
module icache_way_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int WAYS = 2,
  parameter int OUTPUT_REG = 0,
  localparam int BE_WIDTH = DATA_WIDTH / 8,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WAY_W-1:0]           wr_way,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [BE_WIDTH-1:0]        wr_byte_en,
  input  logic                       rd_en,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [WAYS*DATA_WIDTH-1:0] rd_data,
  output logic [WAYS-1:0]            rd_valid,
  output logic                       rd_data_vld,
  input  logic                       inv_req,
  output logic                       inv_busy
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] mem [WAYS][DEPTH];
  logic [WAYS-1:0] valid [DEPTH];
  logic wr_ok, rd_ok, vld1;
  logic [WAYS*DATA_WIDTH-1:0] rd_word, d1;
  logic [WAYS-1:0] rd_vbit, v1;
  assign wr_ok = state == IDLE && wr_en && |wr_byte_en && {1'b0, wr_way} < (WAY_W+1)'(WAYS);
  assign rd_ok = state == IDLE && rd_en;
  assign inv_busy = state == CLEAR;
  // state register; reset parks the sweep at index 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // sweep sequencing: one index per cycle, inv_req always restarts from index 0
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (inv_req) begin
      state_n = CLEAR;
      cnt_n = '0;
    end else if (state == CLEAR) begin
      cnt_n = cnt + 1'b1;
      state_n = cnt == '1 ? IDLE : CLEAR;
    end
  end
  // data RAM: byte-masked write into the addressed way only; contents are never reset
  always_ff @(posedge clk)
    for (int w = 0; w < WAYS; w++)
      for (int b = 0; b < BE_WIDTH; b++)
        if (wr_ok && wr_way == WAY_W'(w) && wr_byte_en[b]) mem[w][wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
  // valid array: the sweep clears a whole index, writes set their own way's bit
  always_ff @(posedge clk)
    if (state == CLEAR) valid[cnt] <= '0;
    else if (wr_ok) valid[wr_addr][wr_way] <= 1'b1;
  // read mux across all ways, optionally forwarding a same-cycle write onto the colliding way
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rd_word[w*DATA_WIDTH +: DATA_WIDTH] = mem[w][rd_addr];
      rd_vbit[w] = valid[rd_addr][w];
`ifdef ICACHE_WAY_BYPASS_EN
      if (wr_ok && wr_addr == rd_addr && wr_way == WAY_W'(w)) begin
        rd_vbit[w] = 1'b1;
        for (int b = 0; b < BE_WIDTH; b++)
          if (wr_byte_en[b]) rd_word[w*DATA_WIDTH + b*8 +: 8] = wr_data[b*8 +: 8];
      end
`endif
    end
  end
  // first read stage: capture accepted reads, hold the last result otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d1 <= '0;
      v1 <= '0;
      vld1 <= 1'b0;
    end else begin
      vld1 <= rd_ok;
      if (rd_ok) begin
        d1 <= rd_word;
        v1 <= rd_vbit;
      end
    end
  if (OUTPUT_REG != 0) begin : g_oreg
    logic [WAYS*DATA_WIDTH-1:0] d2;
    logic [WAYS-1:0] v2;
    logic vld2;
    // output pipeline stage, advancing only when stage one holds a fresh read
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        d2 <= '0;
        v2 <= '0;
        vld2 <= 1'b0;
      end else begin
        vld2 <= vld1;
        if (vld1) begin
          d2 <= d1;
          v2 <= v1;
        end
      end
    assign rd_data = d2;
    assign rd_valid = v2;
    assign rd_data_vld = vld2;
  end else begin : g_noreg
    assign rd_data = d1;
    assign rd_valid = v1;
    assign rd_data_vld = vld1;
  end
endmodule

// File: tb/tb_icache_way_array.sv
// tb_icache_way_array: randomized and directed checks of icache_way_array against an array-based reference model
module tb_icache_way_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic wr_en = 1'b0, wr_way = 1'b0, rd_en = 1'b0, inv_req = 1'b0;
  logic [3:0] wr_addr = '0, rd_addr = '0, wr_byte_en = '0;
  logic [31:0] wr_data = '0;
  logic [63:0] rd_data0, rd_data1;
  logic [1:0] rd_valid0, rd_valid1;
  logic vld0, vld1, busy0, busy1;
  icache_way_array #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WAYS(2), .OUTPUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_way(wr_way), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .rd_data_vld(vld0), .inv_req(inv_req), .inv_busy(busy0));
  icache_way_array #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WAYS(2), .OUTPUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_way(wr_way), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .rd_data_vld(vld1), .inv_req(inv_req), .inv_busy(busy1));
  // reference model: word store, per-byte "known" flags (RAM powers up undefined), valid bits, sweep cycles left
  logic [31:0] mem_m [2][16];
  logic [3:0] kb [2][16];
  logic [1:0] val_m [16];
  int busy_left = 16;
  int tests = 0, fails = 0;
  logic [63:0] h0_d = '0, h0_m = '1, h1_d = '0, h1_m = '1, p_d = '0, p_m = '0;
  logic [1:0] h0_v = '0, h1_v = '0, p_v = '0;
  logic p_acc = 1'b0;
  function automatic logic [31:0] m32(input logic [3:0] k);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{k[b]}};
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // one clock of stimulus; the model predicts and every output of both DUTs is checked afterwards
  task automatic cyc(input logic we, input logic wy, input logic [3:0] wa, input logic [31:0] wd,
                     input logic [3:0] be, input logic re, input logic [3:0] ra, input logic inv);
    logic acc;
    logic [63:0] ed, em;
    logic [1:0] ev;
    wr_en = we; wr_way = wy; wr_addr = wa; wr_data = wd; wr_byte_en = be;
    rd_en = re; rd_addr = ra; inv_req = inv;
    acc = re && busy_left == 0;
    for (int w = 0; w < 2; w++) begin
      logic [31:0] d;
      logic [3:0] k;
      logic v;
      d = mem_m[w][ra];
      k = kb[w][ra];
      v = val_m[ra][w];
`ifdef ICACHE_WAY_BYPASS_EN
      if (we && busy_left == 0 && wy == w && wa == ra) begin
        for (int b = 0; b < 4; b++) if (be[b]) begin d[b*8 +: 8] = wd[b*8 +: 8]; k[b] = 1'b1; end
        v = v | (|be);
      end
`endif
      ed[w*32 +: 32] = d;
      em[w*32 +: 32] = m32(k);
      ev[w] = v;
    end
    if (we && busy_left == 0 && be != 0) begin
      for (int b = 0; b < 4; b++) if (be[b]) begin
        mem_m[wy][wa][b*8 +: 8] = wd[b*8 +: 8];
        kb[wy][wa][b] = 1'b1;
      end
      val_m[wa][wy] = 1'b1;
    end
    if (inv) begin
      busy_left = 16;
      for (int a = 0; a < 16; a++) val_m[a] = '0;
    end else if (busy_left > 0) busy_left--;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; inv_req = 1'b0;
    if (acc) begin h0_d = ed; h0_m = em; h0_v = ev; end
    if (p_acc) begin h1_d = p_d; h1_m = p_m; h1_v = p_v; end
    chk("busy0", busy0, busy_left != 0);
    chk("busy1", busy1, busy_left != 0);
    chk("vld0", vld0, acc);
    chk("data0", rd_data0 & h0_m, h0_d & h0_m);
    chk("valid0", rd_valid0, h0_v);
    chk("vld1", vld1, p_acc);
    chk("data1", rd_data1 & h1_m, h1_d & h1_m);
    chk("valid1", rd_valid1, h1_v);
    p_acc = acc; p_d = ed; p_m = em; p_v = ev;
  endtask
  task automatic idle_until_clear(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      n++;
      if (!busy0) break;
    end
  endtask
  initial begin
    int n;
    for (int w = 0; w < 2; w++) for (int a = 0; a < 16; a++) begin mem_m[w][a] = '0; kb[w][a] = '0; end
    for (int a = 0; a < 16; a++) val_m[a] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 1);
    chk("rst_vld", vld0, 0);
    chk("rst_data", rd_data0, 0);
    chk("rst_valid", rd_valid1, 0);
    rst_n = 1'b1;
    idle_until_clear(n);
    chk("reset_sweep_len", n, 16);
    for (int a = 0; a < 16; a++) begin
      cyc(0, 0, 0, 0, 0, 1, 4'(a), 0);
      chk("swept_valid", rd_valid0, 2'b00);
    end
    cyc(1, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 5, 0);
    chk("way1_data", rd_data0[63:32], 32'hDEADBEEF);
    chk("way1_valid", rd_valid0, 2'b10);
    cyc(1, 0, 3, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    cyc(1, 0, 3, 32'h11223344, 4'b0101, 0, 0, 0);
    cyc(1, 1, 3, 32'h55667788, 4'b0000, 1, 3, 0);
    chk("partial", rd_data0[31:0], 32'hAA22CC44);
    chk("be0_noop_valid", rd_valid0, 2'b01);
    cyc(1, 0, 7, 32'h0, 4'hF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (9) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    idle_until_clear(n);
    chk("restart_sweep_len", n, 16);
    cyc(0, 0, 0, 0, 0, 1, 5, 0);
    chk("inv_valid5", rd_valid0, 2'b00);
    cyc(0, 0, 0, 0, 0, 1, 3, 0);
    chk("inv_valid3", rd_valid0, 2'b00);
    cyc(1, 0, 7, 32'h12345678, 4'hF, 1, 7, 0);
`ifdef ICACHE_WAY_BYPASS_EN
    chk("coll_data", rd_data0[31:0], 32'h12345678);
    chk("coll_valid", rd_valid0[0], 1'b1);
`else
    chk("coll_data", rd_data0[31:0], 32'h0);
    chk("coll_valid", rd_valid0[0], 1'b0);
`endif
    cyc(0, 0, 0, 0, 0, 1, 7, 0);
    chk("after_coll", rd_data0[31:0], 32'h12345678);
    for (int a = 0; a < 4; a++) cyc(1, 1, 4'(a), 32'hC0DE0000 + a, 4'hF, 0, 0, 0);
    for (int a = 0; a < 4; a++) cyc(0, 0, 0, 0, 0, 1, 4'(a), 0);
    chk("oreg_pipe0", rd_data1[63:32], 32'hC0DE0002);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("oreg_pipe_last", rd_data1[63:32], 32'hC0DE0003);
    chk("oreg_vld_tail", vld1, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("oreg_vld_off", vld1, 1'b0);
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          $urandom_range(0, 79) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
